// File: rtl/gen_control_if.sv
// gen_control_if: button inputs, operand latch and run-status bus between the board input layer and the run controller
interface gen_control_if #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W    = 8,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = 1
);
  logic                          set;
  logic                          go;
  logic                          stop;
  logic                          step;
  logic [FIELD_W-1:0]            load_val;
  logic [NUM_FIELDS*FIELD_W-1:0] field_val;
  logic [NUM_FIELDS-1:0]         ld;
  logic [IDX_W-1:0]              field_idx;
  logic                          draw;
  logic                          gen_tick;
  logic [CNT_W-1:0]              gen_count;
  logic [2:0]                    state;
  modport master (
    output set, go, stop, step, load_val,
    input  field_val, ld, field_idx, draw, gen_tick, gen_count, state
  );
  modport slave (
    input  set, go, stop, step, load_val,
    output field_val, ld, field_idx, draw, gen_tick, gen_count, state
  );
endinterface

// File: rtl/gen_control.sv
// gen_control: button edge detection, operand entry and free-run/single-step generation timing for the life simulator
module gen_control #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W    = 8,
  parameter int GEN_PERIOD = 4,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = 1
) (
  input logic         clock,
  input logic         reset,
  gen_control_if.slave bus
);
  localparam int DIV_W = GEN_PERIOD > 1 ? $clog2(GEN_PERIOD) : 1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    STEP  = 3'd4,
    PAUSE = 3'd5
  } state_t;
  state_t           state, state_next;
  logic             set_q, go_q, stop_q, step_q;
  logic             set_rise, go_rise, stop_rise, step_rise;
  logic             latch, last, active, tick;
  logic [IDX_W-1:0] k;
  logic [DIV_W-1:0] div_cnt;
  state_t           latch_target;
  assign set_rise  = bus.set & ~set_q;
  assign go_rise   = bus.go & ~go_q;
  assign stop_rise = bus.stop & ~stop_q;
  assign step_rise = bus.step & ~step_q;
  assign latch  = set_rise && (state == IDLE || state == ENTRY || state == READY || state == PAUSE);
  assign k      = state == ENTRY ? bus.field_idx : '0;
  assign last   = k == IDX_W'(NUM_FIELDS - 1);
  assign active = state == RUN || state == STEP;
  // stop on the tick edge wins: no tick, no count
  assign tick   = active && !stop_rise && div_cnt == DIV_W'(GEN_PERIOD - 1);
  assign latch_target = last ? READY : ENTRY;
  assign bus.draw  = active;
  assign bus.state = state;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ENTRY:  state_next = latch ? latch_target : state;
      READY, PAUSE: state_next = latch ? latch_target : go_rise ? RUN : step_rise ? STEP : state;
      RUN:          state_next = stop_rise ? PAUSE : RUN;
      STEP:         state_next = (stop_rise || tick) ? PAUSE : STEP;
      default:      state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {set_q, go_q, stop_q, step_q} <= '0;
      bus.field_val <= '0;
      bus.ld        <= '0;
      bus.field_idx <= '0;
      bus.gen_tick  <= 1'b0;
      bus.gen_count <= '0;
      div_cnt       <= '0;
    end else begin
      {set_q, go_q, stop_q, step_q} <= {bus.set, bus.go, bus.stop, bus.step};
      bus.ld <= latch ? NUM_FIELDS'(1) << k : '0;
      if (latch) begin
        bus.field_val[k*FIELD_W +: FIELD_W] <= bus.load_val;
        bus.field_idx <= last ? '0 : k + 1'b1;
      end
      div_cnt      <= (active && !stop_rise && !tick) ? div_cnt + 1'b1 : '0;
      bus.gen_tick <= tick;
      if (latch && k == '0) bus.gen_count <= '0;
      else if (tick) bus.gen_count <= bus.gen_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_gen_control.sv
// tb_gen_control: directed-vector bench for gen_control (default build plus a one-field, 2-bit-count build)
module tb_gen_control;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reset_b = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  gen_control_if #(.NUM_FIELDS(2), .FIELD_W(8), .CNT_W(8), .IDX_W(1)) a ();
  gen_control_if #(.NUM_FIELDS(1), .FIELD_W(8), .CNT_W(2), .IDX_W(1)) b ();
  gen_control #(.NUM_FIELDS(2), .FIELD_W(8), .GEN_PERIOD(4), .CNT_W(8), .IDX_W(1)) dut_a (
    .clock(clock), .reset(reset), .bus(a)
  );
  gen_control #(.NUM_FIELDS(1), .FIELD_W(8), .GEN_PERIOD(4), .CNT_W(2), .IDX_W(1)) dut_b (
    .clock(clock), .reset(reset_b), .bus(b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  initial begin
    int n;
    {a.set, a.go, a.stop, a.step} = '0;
    a.load_val = '0;
    {b.go, b.stop, b.step} = '0;
    b.set = 1'b1;
    b.load_val = 8'h9a;
    cyc(2);
    check("rst_state", a.state, 0);
    check("rst_field_val", a.field_val, 0);
    check("rst_ld", a.ld, 0);
    check("rst_idx", a.field_idx, 0);
    check("rst_count", a.gen_count, 0);
    check("rst_draw", a.draw, 0);
    check("rst_tick", a.gen_tick, 0);
    reset = 1'b0;
    cyc(1);
    a.load_val = 8'h12;
    a.set = 1'b1;
    cyc(1);
    check("entry0_ld", a.ld, 2'b01);
    check("entry0_val", a.field_val, 16'h0012);
    check("entry0_state", a.state, 1);
    check("entry0_idx", a.field_idx, 1);
    a.set = 1'b0;
    a.load_val = 8'h34;
    cyc(1);
    check("entry_ld_clear", a.ld, 0);
    a.set = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (i == 0) check("entry1_ld", a.ld, 2'b10);
      n += (a.ld == 2'b10) ? 1 : 0;
    end
    check("entry_ld_pulses", n, 1);
    check("entry_val", a.field_val, 16'h3412);
    check("entry_state", a.state, 2);
    check("entry_idx", a.field_idx, 0);
    a.set = 1'b0;
    cyc(1);
    a.go = 1'b1;
    cyc(1);
    check("run_state", a.state, 3);
    check("run_draw", a.draw, 1);
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      check("run_tick", a.gen_tick, (i % 4 == 0) ? 1 : 0);
      if (i % 4 == 0) check("run_count", a.gen_count, i / 4);
    end
    a.go = 1'b0;
    a.stop = 1'b1;
    cyc(1);
    check("stop_state", a.state, 5);
    check("stop_draw", a.draw, 0);
    check("stop_count", a.gen_count, 3);
    a.stop = 1'b0;
    cyc(1);
    a.step = 1'b1;
    cyc(1);
    check("step_state", a.state, 4);
    n = a.draw;
    a.go = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      n += a.draw;
      check("step_tick", a.gen_tick, (i == 4) ? 1 : 0);
    end
    check("step_draw_cycles", n, 4);
    check("step_count", a.gen_count, 4);
    check("step_state_end", a.state, 5);
    cyc(1);
    check("step_go_held", a.state, 5);
    check("step_tick_clear", a.gen_tick, 0);
    a.go = 1'b0;
    a.step = 1'b0;
    cyc(1);
    a.load_val = 8'h56;
    a.set = 1'b1;
    a.go = 1'b1;
    cyc(1);
    check("setgo_state", a.state, 1);
    check("setgo_val", a.field_val, 16'h3456);
    check("setgo_ld", a.ld, 2'b01);
    check("setgo_count", a.gen_count, 0);
    a.set = 1'b0;
    a.go = 1'b0;
    cyc(1);
    a.load_val = 8'h78;
    a.set = 1'b1;
    cyc(1);
    check("reentry_state", a.state, 2);
    check("reentry_val", a.field_val, 16'h7856);
    a.set = 1'b0;
    a.go = 1'b1;
    cyc(1);
    check("tickstop_run", a.state, 3);
    cyc(3);
    a.stop = 1'b1;
    cyc(1);
    check("tickstop_tick", a.gen_tick, 0);
    check("tickstop_count", a.gen_count, 0);
    check("tickstop_state", a.state, 5);
    a.go = 1'b0;
    a.stop = 1'b0;
    cyc(1);
    a.go = 1'b1;
    cyc(13);
    check("midrun_count", a.gen_count, 3);
    check("midrun_state", a.state, 3);
    #2 reset = 1'b1;
    #1;
    check("async_state", a.state, 0);
    check("async_draw", a.draw, 0);
    check("async_count", a.gen_count, 0);
    check("async_val", a.field_val, 0);
    a.go = 1'b0;
    cyc(1);
    reset_b = 1'b0;
    cyc(1);
    check("wrap_state", b.state, 2);
    check("wrap_ld", b.ld, 1);
    check("wrap_val", b.field_val, 8'h9a);
    b.set = 1'b0;
    b.go = 1'b1;
    cyc(1);
    check("wrap_run", b.state, 3);
    for (int g = 1; g <= 5; g++) begin
      cyc(4);
      check("wrap_tick", b.gen_tick, 1);
      check("wrap_count", b.gen_count, g % 4);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gen_control.md
# gen_control

Parametrised run controller for the life simulator. It turns debounced push-button levels (`set`, `go`, `stop`, `step`) into rising-edge events and latches `NUM_FIELDS` operand words from `load_val` in sequence. It then drives the draw/evolve datapath either free-running or single-step, producing a generation tick every `GEN_PERIOD` cycles and a wrapping generation count. It sits between the board input layer and the grid/draw datapath.

## Interface
- `NUM_FIELDS`, default 2: number of words latched per entry sequence (≥1; X,Y by default).
- `FIELD_W`, default 8: width of each latched word.
- `GEN_PERIOD`, default 4: clock cycles per generation while evolving (≥1).
- `CNT_W`, default 8: width of the generation counter.
- `IDX_W`, default 1: width of `field_idx`; must satisfy 2^IDX_W ≥ `NUM_FIELDS`.
- `clock  in  1  sole clock, all state on rising edge`
- `reset  in  1  asynchronous, active-high; clears all state`
- `set  in  1  level, synchronous to clock; rising edge = latch/enter`
- `go  in  1  level; rising edge = start free-running evolution`
- `stop  in  1  level; rising edge = pause evolution`
- `step  in  1  level; rising edge = run exactly one generation`
- `load_val  in  FIELD_W  operand captured on set edge`
- `field_val  out  NUM_FIELDS*FIELD_W  latched words; field i at [i*FIELD_W +: FIELD_W]`
- `ld  out  NUM_FIELDS  one-cycle registered strobe, bit i when field i latched`
- `field_idx  out  IDX_W  index of the next field to be latched in ENTRY`
- `draw  out  1  high in RUN and STEP (Moore, decoded from state)`
- `gen_tick  out  1  registered one-cycle pulse per completed generation`
- `gen_count  out  CNT_W  completed generations, modulo 2^CNT_W`
- `state  out  3  IDLE=0, ENTRY=1, READY=2, RUN=3, STEP=4, PAUSE=5`

## Operation
- Edge detect: one register per button; `x_rise = x & ~x_q`. A button held through reset release yields one rise on the first edge. A held button never yields a second rise.
- Latch event (a `set_rise` accepted in IDLE, ENTRY, READY or PAUSE):
  - Effective index k = `field_idx` in ENTRY, 0 otherwise.
  - `field_val[k] <= load_val`, `ld[k] <= 1`.
  - If k = `NUM_FIELDS`-1: go to READY and set `field_idx` to 0. Otherwise go to ENTRY with `field_idx` = k+1.
  - A latch with k=0 also clears `gen_count`.
- IDLE: only `set` acts.
- ENTRY: only `set` acts; `go`, `step` and `stop` are ignored.
- READY / PAUSE: priority set > go > step.
  - `go` goes to RUN.
  - `step` goes to STEP.
  - `stop` is ignored.
- RUN: `stop_rise` goes to PAUSE; all other buttons are ignored.
- STEP: `stop_rise` goes to PAUSE with no tick. The generation's tick goes to PAUSE.
- Divider `div_cnt` (0..`GEN_PERIOD`-1):
  - Zero outside RUN/STEP and on entry to either state.
  - In RUN/STEP without `stop_rise`, it increments each edge.
  - When it equals `GEN_PERIOD`-1: it wraps to 0, `gen_tick <= 1`, and `gen_count` increments with wrap.
- A `stop_rise` on the tick edge suppresses the tick and the count increment.
- Unused state encodings return to IDLE on the next edge.

## Timing
- Reset values: `state`=IDLE, `field_val`=0, `ld`=0, `field_idx`=0, `gen_tick`=0, `gen_count`=0, `draw`=0, edge registers=0, `div_cnt`=0. Reset takes effect immediately, including mid-RUN; outputs are zero with no clock.
- `ld` and `field_val` update on the edge that samples `set` rising; `ld` is high for exactly the following cycle.
- The go-rise edge is E0; `draw` is high from the cycle after E0.
- The first `gen_tick` is high in the cycle after edge E0+`GEN_PERIOD`. Subsequent ticks follow every `GEN_PERIOD` cycles.
- With `GEN_PERIOD`=1, `gen_tick` is high every cycle in RUN.
- STEP: `draw` is high for exactly `GEN_PERIOD` cycles. It falls in the same cycle `gen_tick` rises.
- `stop`: `draw` falls in the cycle after the sampling edge.

## Test plan
- Reset: assert `reset` asynchronously mid-RUN with `gen_count`=3 -> before any clock edge, `state`=0, `draw`=0, `gen_count`=0, `field_val`=0.
- Entry (defaults): set pulse with `load_val`=0x12, then set held 5 cycles with `load_val`=0x34.
  - `ld`=01, then exactly one 10 pulse.
  - `field_val`=0x3412, `state`=2, `field_idx`=0.
- Run (`GEN_PERIOD`=4): go rise at E0.
  - `gen_tick` in the cycles after E4, E8 and E12; `gen_count` = 1, 2, 3.
  - stop rise -> `state`=5, `draw`=0, count held.
- Step: step rise in PAUSE -> `draw` high exactly 4 cycles, one tick, `gen_count`+1, `state`=5.
  - Go held during STEP -> no effect.
- Simultaneous:
  - set+go rise in PAUSE -> `state`=1, field 0 latched, `gen_count`=0.
  - stop rise on a RUN tick edge -> no `gen_tick`, count unchanged, `state`=5.
- Wrap (`CNT_W`=2, `NUM_FIELDS`=1): single set -> READY directly. Run 5 generations -> `gen_count` 1,2,3,0,1.
